fp_add_scheduler: RTL and testbench



---
 rtl/fp_add_scheduler_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 61 ++++++
 rtl/fp_add_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_fp_add_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_scheduler_pkg.sv
// Shared types and constants for the FP16 adder scheduler.
// Holds the FP16 word layout, the scheduler state encoding and the default datapath latency.
package fp_add_scheduler_pkg;

    localparam int C_SCHED_DEF_LATENCY = 2;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] mant;
    } fp16_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from an internal pointer for the first requester.
// The pointer advances past the winner only when a grant is actually given.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               grant_en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    winner
);

    logic [ID_W-1:0] ptr_r;
    logic [ID_W-1:0] idx_s;
    logic            found_s;
    int              sum_s;

    // Winner search from ptr_r upward, wrapping modulo NUM_REQ.
    always_comb begin
        grant   = '0;
        winner  = '0;
        found_s = 1'b0;
        idx_s   = '0;
        sum_s   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            sum_s = int'(ptr_r) + off;
            if (sum_s >= NUM_REQ) begin
                idx_s = ID_W'(sum_s - NUM_REQ);
            end else begin
                idx_s = ID_W'(sum_s);
            end
            if (!found_s && req[idx_s]) begin
                found_s = 1'b1;
                winner  = idx_s;
            end else begin
                found_s = found_s;
            end
        end
        if (grant_en && found_s) begin
            grant[winner] = 1'b1;
        end else begin
            grant = '0;
        end
    end

    // Pointer moves to the slot after the winner on every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (|grant) begin
            if (winner == ID_W'(NUM_REQ - 1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= winner + ID_W'(1);
            end
        end
    end

endmodule

// File: rtl/fp_add_scheduler.sv
// Time-shares one FP16 adder datapath among NUM_REQ requesters with round-robin issue,
// a latency-matched ID tag pipeline for result routing and a flush/drain close sequence.
module fp_add_scheduler
    import fp_add_scheduler_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int ADD_LATENCY = C_SCHED_DEF_LATENCY,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          en_i,
    input  logic                          flush_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op_a_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op_b_i,
    output logic                          add_valid_o,
    output logic [DATA_WIDTH-1:0]         add_op_a_o,
    output logic [DATA_WIDTH-1:0]         add_op_b_o,
    input  logic [DATA_WIDTH-1:0]         add_result_i,
    output logic [NUM_REQ-1:0]            resp_valid_o,
    output logic [DATA_WIDTH-1:0]         resp_result_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int CNT_W = $clog2(ADD_LATENCY + 3);

    sched_state_e          state_r, state_nxt_s;
    logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
    logic                  grant_en_s, hs_s, resp_any_s;
    logic [ID_W-1:0]       winner_s;
    logic [DATA_WIDTH-1:0] sel_a_s, sel_b_s;
    logic [NUM_REQ-1:0]    resp_oh_s;
    logic [ADD_LATENCY:0]  tag_vld_r;
    logic [ID_W-1:0]       tag_id_r [ADD_LATENCY+1];

    // Grants only while running, enabled and not being flushed.
    always_comb begin
        grant_en_s = 1'b0;
        if ((state_r == RUN) && en_i && !flush_i) begin
            grant_en_s = 1'b1;
        end else begin
            grant_en_s = 1'b0;
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .req      (req_valid_i),
        .grant_en (grant_en_s),
        .grant    (req_ready_o),
        .winner   (winner_s)
    );

    assign hs_s       = |req_ready_o;
    assign resp_any_s = |resp_valid_o;

    // Operand mux from the current winner.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner_s == ID_W'(i)) begin
                sel_a_s = req_op_a_i[i*DATA_WIDTH +: DATA_WIDTH];
                sel_b_s = req_op_b_i[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                sel_a_s = sel_a_s;
                sel_b_s = sel_b_s;
            end
        end
    end

    // In-flight count: +1 per issue, -1 per delivered response.
    always_comb begin
        cnt_nxt_s = cnt_r;
        case ({hs_s, resp_any_s})
            2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1);
            2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1);
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Drain completes once the count reaches zero at the end of this cycle,
    // so done lands on the cycle right after the final response.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (flush_i) begin
                    state_nxt_s = DONE;
                end else if (en_i) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (flush_i) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                if (cnt_nxt_s == '0) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, count and the status outputs derived from next-state values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_o  <= (state_nxt_s != IDLE) || (cnt_nxt_s != '0);
            done_o  <= (state_nxt_s == DONE);
        end
    end

    // Issue stage: operands hold their last value between issues.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            add_valid_o <= 1'b0;
            add_op_a_o  <= '0;
            add_op_b_o  <= '0;
        end else begin
            add_valid_o <= hs_s;
            if (hs_s) begin
                add_op_a_o <= sel_a_s;
                add_op_b_o <= sel_b_s;
            end
        end
    end

    // Tag pipeline: stage 0 aligns with the issue stage, last stage with add_result_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_vld_r <= '0;
            for (int k = 0; k <= ADD_LATENCY; k++) begin
                tag_id_r[k] <= '0;
            end
        end else begin
            tag_vld_r[0] <= hs_s;
            tag_id_r[0]  <= winner_s;
            for (int k = 1; k <= ADD_LATENCY; k++) begin
                tag_vld_r[k] <= tag_vld_r[k-1];
                tag_id_r[k]  <= tag_id_r[k-1];
            end
        end
    end

    // One-hot owner of the result currently at the datapath output.
    always_comb begin
        resp_oh_s = '0;
        resp_oh_s[tag_id_r[ADD_LATENCY]] = 1'b1;
    end

    // Response register routes the sampled result to its owner for one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_o  <= '0;
            resp_result_o <= '0;
        end else if (tag_vld_r[ADD_LATENCY]) begin
            resp_valid_o  <= resp_oh_s;
            resp_result_o <= add_result_i;
        end else begin
            resp_valid_o  <= '0;
        end
    end

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Self-checking bench for fp_add_scheduler: directed scenarios plus random traffic
// checked against a queue-based reference model; a second instance covers ADD_LATENCY=0.
module tb_fp_add_scheduler;

    localparam int L = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, flush;
    logic [3:0]  req_valid, req_ready, resp_valid;
    logic [63:0] op_a, op_b;
    logic        add_valid, busy, done;
    logic [15:0] add_op_a, add_op_b, add_result, resp_result;
    logic [15:0] d1, d2;

    logic        en0, flush0, add_valid0, busy0, done0;
    logic [3:0]  valid0, ready0, resp_valid0;
    logic [63:0] op_a0, op_b0;
    logic [15:0] add_op_a0, add_op_b0, add_result0, resp_result0;

    typedef struct { int due; logic [15:0] a; logic [15:0] b; } iss_t;
    typedef struct { int due; int id; logic [15:0] res; } rsp_t;
    iss_t iss_q[$];
    rsp_t rsp_q[$];
    int   mode, mptr, cycle;
    int   n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    // Stand-in for the FP adder: a fixed known sum plus a scrambled mix otherwise.
    function automatic logic [15:0] fake_add(input logic [15:0] a, input logic [15:0] b);
        if (a == 16'h3C00 && b == 16'h4000) return 16'h4200;
        return a + {b[7:0], b[15:8]};
    endfunction

    fp_add_scheduler #(.NUM_REQ(4), .DATA_WIDTH(16), .ADD_LATENCY(L)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_a_i(op_a), .req_op_b_i(op_b),
        .add_valid_o(add_valid), .add_op_a_o(add_op_a), .add_op_b_o(add_op_b),
        .add_result_i(add_result),
        .resp_valid_o(resp_valid), .resp_result_o(resp_result),
        .busy_o(busy), .done_o(done));

    fp_add_scheduler #(.NUM_REQ(4), .DATA_WIDTH(16), .ADD_LATENCY(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en0), .flush_i(flush0),
        .req_valid_i(valid0), .req_ready_o(ready0),
        .req_op_a_i(op_a0), .req_op_b_i(op_b0),
        .add_valid_o(add_valid0), .add_op_a_o(add_op_a0), .add_op_b_o(add_op_b0),
        .add_result_i(add_result0),
        .resp_valid_o(resp_valid0), .resp_result_o(resp_result0),
        .busy_o(busy0), .done_o(done0));

    // Two-cycle datapath for the main instance; combinational one for the L=0 instance.
    always @(posedge clk) begin
        d1 <= fake_add(add_op_a, add_op_b);
        d2 <= d1;
    end
    assign add_result  = d2;
    assign add_result0 = fake_add(add_op_a0, add_op_b0);

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // Reference model: checks this cycle's outputs, then advances to the next cycle.
    task automatic model_check();
        logic [3:0] eg;
        int         win;
        eg  = 4'b0000;
        win = -1;
        chk_eq("busy", busy, (mode != M_IDLE) || (rsp_q.size() != 0));
        chk_eq("done", done, mode == M_DONE);
        if (mode == M_RUN && en && !flush) begin
            for (int k = 0; k < 4; k++) begin
                int j = (mptr + k) % 4;
                if (win < 0 && req_valid[j]) win = j;
            end
        end
        if (win >= 0) eg[win] = 1'b1;
        chk_eq("ready", req_ready, eg);
        if (iss_q.size() > 0 && iss_q[0].due == cycle) begin
            chk_eq("add_valid", add_valid, 1);
            chk_eq("add_op_a", add_op_a, iss_q[0].a);
            chk_eq("add_op_b", add_op_b, iss_q[0].b);
            void'(iss_q.pop_front());
        end else begin
            chk_eq("add_valid", add_valid, 0);
        end
        if (rsp_q.size() > 0 && rsp_q[0].due == cycle) begin
            chk_eq("resp_valid", resp_valid, 32'd1 << rsp_q[0].id);
            chk_eq("resp_result", resp_result, rsp_q[0].res);
            void'(rsp_q.pop_front());
        end else begin
            chk_eq("resp_valid", resp_valid, 0);
        end
        if (win >= 0) begin
            iss_t ie;
            rsp_t re;
            ie.due = cycle + 1;
            ie.a   = op_a[win*16 +: 16];
            ie.b   = op_b[win*16 +: 16];
            re.due = cycle + 2 + L;
            re.id  = win;
            re.res = fake_add(ie.a, ie.b);
            iss_q.push_back(ie);
            rsp_q.push_back(re);
            mptr = (win + 1) % 4;
        end
        case (mode)
            M_IDLE:  mode = flush ? M_DONE : (en ? M_RUN : M_IDLE);
            M_RUN:   mode = flush ? M_DRAIN : M_RUN;
            M_DRAIN: mode = (rsp_q.size() == 0) ? M_DONE : M_DRAIN;
            default: mode = M_IDLE;
        endcase
    endtask

    task automatic tick_check();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        cycle++;
        #1;
    endtask

    task automatic cyc();
        tick_check();
        advance();
    endtask

    task automatic model_clear();
        iss_q.delete();
        rsp_q.delete();
        mode = M_IDLE;
        mptr = 0;
    endtask

    initial begin
        int lr, dc;
        rst_n = 1'b0; en = 1'b0; flush = 1'b0; req_valid = 4'b0000;
        op_a = 64'd0; op_b = 64'd0; cycle = 0;
        en0 = 1'b1; flush0 = 1'b0; valid0 = 4'b0000; op_a0 = 64'd0; op_b0 = 64'd0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single requester with the known 1.0 + 2.0 pair.
        en = 1'b1;
        cyc();
        req_valid = 4'b0010; op_a[16 +: 16] = 16'h3C00; op_b[16 +: 16] = 16'h4000;
        tick_check(); chk_eq("single_ready", req_ready, 4'b0010); advance();
        req_valid = 4'b0000;
        tick_check(); chk_eq("single_issue", add_valid, 1); advance();
        cyc(); cyc();
        tick_check();
        chk_eq("single_resp_v", resp_valid, 4'b0010);
        chk_eq("single_resp_d", resp_result, 16'h4200);
        advance();

        // All requesters valid: rotation continues from slot 2.
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
            tick_check(); chk_eq("rr_grant", req_ready, 32'd1 << ((2 + k) % 4)); advance();
        end
        req_valid = 4'b0000;
        repeat (5) cyc();

        // Fairness with gaps.
        req_valid = 4'b0001; cyc();
        req_valid = 4'b0101; tick_check(); chk_eq("fair_g2", req_ready, 4'b0100); advance();
        req_valid = 4'b0001; tick_check(); chk_eq("fair_g0", req_ready, 4'b0001); advance();
        req_valid = 4'b1001; tick_check(); chk_eq("fair_g3", req_ready, 4'b1000); advance();

        // en low in RUN stalls grants.
        en = 1'b0; req_valid = 4'b1111;
        tick_check(); chk_eq("en_low_ready", req_ready, 4'b0000); advance();
        en = 1'b1; req_valid = 4'b0000;
        repeat (5) cyc();

        // Flush with three ops in flight and a competing request.
        req_valid = 4'b1111;
        repeat (3) cyc();
        flush = 1'b1; req_valid = 4'b0010;
        tick_check(); chk_eq("flush_no_grant", req_ready, 4'b0000); advance();
        flush = 1'b0; req_valid = 4'b0000;
        lr = -1; dc = -1;
        for (int k = 0; k < 20 && dc < 0; k++) begin
            tick_check();
            if (resp_valid != 4'b0000) lr = cycle;
            if (done) dc = cycle;
            advance();
        end
        chk_eq("drain_done_gap", dc - lr, 1);
        en = 1'b0; flush = 1'b1;
        tick_check(); chk_eq("idle_not_busy", busy, 0); advance();
        flush = 1'b0;
        tick_check(); chk_eq("idle_flush_done", done, 1); advance();

        // Async reset between edges with two ops in flight.
        en = 1'b1;
        cyc();
        req_valid = 4'b1111;
        repeat (2) cyc();
        req_valid = 4'b0000;
        tick_check();
        #2 rst_n = 1'b0;
        #1;
        chk_eq("rst_ready", req_ready, 0);
        chk_eq("rst_add_valid", add_valid, 0);
        chk_eq("rst_add_a", add_op_a, 0);
        chk_eq("rst_resp_v", resp_valid, 0);
        chk_eq("rst_resp_d", resp_result, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_done", done, 0);
        advance(); advance();
        rst_n = 1'b1;
        model_clear();
        repeat (6) cyc();

        // ADD_LATENCY=0 instance: response two cycles after the handshake.
        valid0 = 4'b0100; op_a0[32 +: 16] = 16'h1234; op_b0[32 +: 16] = 16'h0F0F;
        tick_check(); chk_eq("l0_ready", ready0, 4'b0100); advance();
        valid0 = 4'b0000;
        tick_check();
        chk_eq("l0_issue", add_valid0, 1);
        chk_eq("l0_no_early", resp_valid0, 0);
        advance();
        tick_check();
        chk_eq("l0_resp_v", resp_valid0, 4'b0100);
        chk_eq("l0_resp_d", resp_result0, fake_add(16'h1234, 16'h0F0F));
        advance();

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            req_valid = 4'($urandom_range(0, 15));
            op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
            en = ($urandom % 8) != 0;
            flush = ($urandom % 50) == 0;
            cyc();
        end
        req_valid = 4'b0000; flush = 1'b0;
        repeat (8) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
